// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the five-stage pipeline hazard controller.
//   state_t  : controller state (RUN, WAIT, ERR)
//   FWD_*    : EX operand source select encodings
//   REG_W    : register-number width
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Combinational forwarding select for one EX operand.
//   ex_src_i          : source register number held in ID/EX
//   mem_reg_write_i   : EX/MEM writes a register
//   mem_write_addr_i  : EX/MEM destination register
//   wb_reg_write_i    : MEM/WB writes a register
//   wb_write_addr_i   : MEM/WB destination register
//   fwd_o             : FWD_MEM, FWD_WB or FWD_RF
// ---------------------------------------------------------------------------
module fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ex_src_i,
    input  logic             mem_reg_write_i,
    input  logic [REG_W-1:0] mem_write_addr_i,
    input  logic             wb_reg_write_i,
    input  logic [REG_W-1:0] wb_write_addr_i,
    output logic [1:0]       fwd_o
);

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    // Register 0 is hard-wired to zero and must never be forwarded.
    always_comb begin
        fwd_o = FWD_RF;
        if (mem_reg_write_i && (mem_write_addr_i != '0) &&
            (mem_write_addr_i == ex_src_i)) begin
            fwd_o = FWD_MEM;
        end else if (wb_reg_write_i && (wb_write_addr_i != '0) &&
                     (wb_write_addr_i == ex_src_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Hazard / stall controller for a five-stage MIPS32 pipeline. Produces the
// pipeline register enables and flushes, sequences EX/MEM data-memory
// accesses over a req/ready handshake with a timeout, selects EX operand
// forwarding and counts stall cycles.
//
// Ports
//   clock_i, reset_i              clock, synchronous active-low reset
//   id_rs_i, id_rt_i              ID source registers
//   id_uses_rs_i, id_uses_rt_i    ID instruction reads rs / rt
//   ex_rs_i, ex_rt_i              ID/EX source registers
//   ex_mem_read_i, ex_reg_write_i ID/EX control bits
//   ex_write_addr_i               ID/EX destination register
//   branch_taken_i                branch/jump taken in EX
//   mem_mem_read_i, mem_mem_write_i, mem_reg_write_i  EX/MEM control bits
//   mem_write_addr_i              EX/MEM destination register
//   wb_reg_write_i, wb_write_addr_i  MEM/WB control / destination
//   dmem_ready_i                  data memory completes access this cycle
//   pc_en_o, ifid_en_o, idex_en_o, exmem_en_o   register load enables
//   ifid_flush_o, idex_flush_o, memwb_flush_o   bubble inserts
//   dmem_req_o                    data-memory request
//   fwd_a_o, fwd_b_o              EX operand source selects
//   mem_timeout_o                 sticky dmem timeout flag
//   stall_cycles_o                saturating count of cycles with pc_en_o = 0
//
// state | meaning
// RUN   | pipeline flowing; a dmem access not ready this cycle freezes it
// WAIT  | pipeline frozen waiting for dmem_ready, wait_cnt counts cycles
// ERR   | dmem timed out; everything stopped until reset
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic [REG_W-1:0] ex_rs_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_reg_write_i,
    input  logic [REG_W-1:0] ex_write_addr_i,
    input  logic             branch_taken_i,
    input  logic             mem_mem_read_i,
    input  logic             mem_mem_write_i,
    input  logic             mem_reg_write_i,
    input  logic [REG_W-1:0] mem_write_addr_i,
    input  logic             wb_reg_write_i,
    input  logic [REG_W-1:0] wb_write_addr_i,
    input  logic             dmem_ready_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             idex_en_o,
    output logic             exmem_en_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             memwb_flush_o,
    output logic             dmem_req_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             mem_timeout_o,
    output logic [31:0]      stall_cycles_o
);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic       mem_acc;
    logic       mem_stall;
    logic       load_use;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // ex_reg_write is implied by ex_mem_read for a load; not needed here.
    logic unused_ex_reg_write;
    assign unused_ex_reg_write = ex_reg_write_i;

    assign mem_acc = mem_mem_read_i | mem_mem_write_i;

    // In WAIT the frozen EX/MEM register still holds the access, so only
    // ready matters there.
    assign mem_stall = ((state_q == ST_RUN)  && mem_acc && !dmem_ready_i) ||
                       ((state_q == ST_WAIT) && !dmem_ready_i);

    assign load_use = ex_mem_read_i && (ex_write_addr_i != '0) &&
                      (((ex_write_addr_i == id_rs_i) && id_uses_rs_i) ||
                       ((ex_write_addr_i == id_rt_i) && id_uses_rt_i));

    always_comb begin
        pc_en_o       = 1'b1;
        ifid_en_o     = 1'b1;
        idex_en_o     = 1'b1;
        exmem_en_o    = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        memwb_flush_o = 1'b0;
        dmem_req_o    = 1'b0;
        if (!reset_i || (state_q == ST_ERR)) begin
            pc_en_o    = 1'b0;
            ifid_en_o  = 1'b0;
            idex_en_o  = 1'b0;
            exmem_en_o = 1'b0;
        end else begin
            dmem_req_o = mem_acc;
            if (mem_stall) begin
                pc_en_o       = 1'b0;
                ifid_en_o     = 1'b0;
                idex_en_o     = 1'b0;
                exmem_en_o    = 1'b0;
                memwb_flush_o = 1'b1;
            end else if (branch_taken_i) begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (load_use) begin
                pc_en_o      = 1'b0;
                ifid_en_o    = 1'b0;
                idex_flush_o = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_timeout_d  = mem_timeout_q;
        stall_cycles_d = stall_cycles_q;
        if (!pc_en_o && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        case (state_q)
            ST_RUN: begin
                if (mem_acc && !dmem_ready_i) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            ST_WAIT: begin
                if (dmem_ready_i) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == 8'(WAIT_MAX)) begin
                    state_d       = ST_ERR;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= 8'd0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_timeout_o  = mem_timeout_q;
    assign stall_cycles_o = stall_cycles_q;

    fwd_unit u_fwd_a (
        .ex_src_i         (ex_rs_i),
        .mem_reg_write_i  (mem_reg_write_i),
        .mem_write_addr_i (mem_write_addr_i),
        .wb_reg_write_i   (wb_reg_write_i),
        .wb_write_addr_i  (wb_write_addr_i),
        .fwd_o            (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .ex_src_i         (ex_rt_i),
        .mem_reg_write_i  (mem_reg_write_i),
        .mem_write_addr_i (mem_write_addr_i),
        .wb_reg_write_i   (wb_reg_write_i),
        .wb_write_addr_i  (wb_write_addr_i),
        .fwd_o            (fwd_b_raw)
    );

    assign fwd_a_o = reset_i ? fwd_a_raw : FWD_RF;
    assign fwd_b_o = reset_i ? fwd_b_raw : FWD_RF;

endmodule
